// File: rtl/mem_stage.sv
// Memory-access stage of the RV32 pipeline: ALU results pass through, loads/stores
// run a req/ready/rvalid handshake with data memory and stall EX/M until done.
module mem_stage #(
   parameter int unsigned ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [4:0]        rd_addr_in,
   input  logic [31:0]       rd_in,
   input  logic              writeback_en_in,
   input  logic              writeback_from_mem_in,
   input  logic              store_en_in,
   input  logic [31:0]       store_data_in,
   input  logic [1:0]        mem_size_in,
   input  logic              mem_unsigned_in,
   output logic              stall,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [31:0]       dmem_wdata,
   output logic [3:0]        dmem_be,
   input  logic              dmem_ready,
   input  logic              dmem_rvalid,
   input  logic [31:0]       dmem_rdata,
   output logic              wb_valid,
   output logic [4:0]        wb_rd_addr,
   output logic [31:0]       wb_data,
   output logic              wb_en,
   output logic              misalign_fault
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

   state_t state_q, state_d;

   // captured request
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [1:0]        size_q, size_d;
   logic              uns_q, uns_d;
   logic [4:0]        rd_q, rd_d;
   logic              wben_q, wben_d;
   logic              we_q, we_d;
   logic [3:0]        be_q, be_d;
   logic [31:0]       wdata_q, wdata_d;

   // writeback
   logic              wb_valid_q, wb_valid_d;
   logic [4:0]        wb_rd_q, wb_rd_d;
   logic [31:0]       wb_data_q, wb_data_d;
   logic              wb_en_q, wb_en_d;
   logic              fault_q, fault_d;

   logic              cap_en;
   logic              mem_op;
   logic              misaligned;
   logic [ADDR_W-1:0] eff_addr;
   logic [3:0]        req_be;
   logic [31:0]       req_wdata;
   logic [31:0]       rdata_sh;
   logic [31:0]       load_res;

   assign eff_addr = rd_in[ADDR_W-1:0];
   assign mem_op   = in_valid & (writeback_from_mem_in | store_en_in);

   // size 11 behaves as word, so bit 1 alone selects word
   assign misaligned = (mem_size_in == 2'b01 && eff_addr[0]) ||
                       (mem_size_in[1] && eff_addr[1:0] != 2'b00);

   always_comb begin
      req_be    = 4'b1111;
      req_wdata = store_data_in;
      case (mem_size_in)
         2'b00: begin
            req_be    = 4'b0001 << eff_addr[1:0];
            req_wdata = {4{store_data_in[7:0]}};
         end
         2'b01: begin
            req_be    = 4'b0011 << eff_addr[1:0];
            req_wdata = {2{store_data_in[15:0]}};
         end
         default: begin
            req_be    = 4'b1111;
            req_wdata = store_data_in;
         end
      endcase
   end

   assign rdata_sh = dmem_rdata >> {addr_q[1:0], 3'b000};

   always_comb begin
      load_res = rdata_sh;
      case (size_q)
         2'b00:   load_res = uns_q ? {24'd0, rdata_sh[7:0]}
                                   : {{24{rdata_sh[7]}}, rdata_sh[7:0]};
         2'b01:   load_res = uns_q ? {16'd0, rdata_sh[15:0]}
                                   : {{16{rdata_sh[15]}}, rdata_sh[15:0]};
         default: load_res = rdata_sh;
      endcase
   end

   // state register
   always_ff @(posedge clk) begin
      if (!rst) state_q <= S_IDLE;
      else      state_q <= state_d;
   end

   // next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (mem_op && !misaligned) state_d = S_REQ;
         S_REQ:  if (dmem_ready) state_d = we_q ? S_IDLE : S_WAIT;
         S_WAIT: if (dmem_rvalid) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // output / datapath next-state logic
   always_comb begin
      stall      = 1'b0;
      cap_en     = 1'b0;
      wb_valid_d = 1'b0;
      wb_en_d    = 1'b0;
      fault_d    = 1'b0;
      wb_data_d  = wb_data_q;
      wb_rd_d    = wb_rd_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid && !mem_op) begin
               wb_valid_d = 1'b1;
               wb_data_d  = rd_in;
               wb_rd_d    = rd_addr_in;
               wb_en_d    = writeback_en_in;
            end else if (mem_op && misaligned) begin
               wb_valid_d = 1'b1;
               fault_d    = 1'b1;
            end else if (mem_op) begin
               stall  = 1'b1;
               cap_en = 1'b1;
            end
         end
         S_REQ: begin
            stall = !(we_q && dmem_ready);
            if (we_q && dmem_ready) wb_valid_d = 1'b1;
         end
         S_WAIT: begin
            stall = !dmem_rvalid;
            if (dmem_rvalid) begin
               wb_valid_d = 1'b1;
               wb_data_d  = load_res;
               wb_rd_d    = rd_q;
               wb_en_d    = wben_q;
            end
         end
         default: stall = 1'b0;
      endcase
   end

   // store wins when both load and store flags are set
   always_comb begin
      addr_d  = cap_en ? eff_addr        : addr_q;
      size_d  = cap_en ? mem_size_in     : size_q;
      uns_d   = cap_en ? mem_unsigned_in : uns_q;
      rd_d    = cap_en ? rd_addr_in      : rd_q;
      wben_d  = cap_en ? writeback_en_in : wben_q;
      we_d    = cap_en ? store_en_in     : we_q;
      be_d    = cap_en ? req_be          : be_q;
      wdata_d = cap_en ? req_wdata       : wdata_q;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         addr_q     <= '0;
         size_q     <= 2'b00;
         uns_q      <= 1'b0;
         rd_q       <= 5'd0;
         wben_q     <= 1'b0;
         we_q       <= 1'b0;
         be_q       <= 4'd0;
         wdata_q    <= 32'd0;
         wb_valid_q <= 1'b0;
         wb_rd_q    <= 5'd0;
         wb_data_q  <= 32'd0;
         wb_en_q    <= 1'b0;
         fault_q    <= 1'b0;
      end else begin
         addr_q     <= addr_d;
         size_q     <= size_d;
         uns_q      <= uns_d;
         rd_q       <= rd_d;
         wben_q     <= wben_d;
         we_q       <= we_d;
         be_q       <= be_d;
         wdata_q    <= wdata_d;
         wb_valid_q <= wb_valid_d;
         wb_rd_q    <= wb_rd_d;
         wb_data_q  <= wb_data_d;
         wb_en_q    <= wb_en_d;
         fault_q    <= fault_d;
      end
   end

   assign dmem_req       = (state_q == S_REQ);
   assign dmem_we        = we_q;
   assign dmem_addr      = {addr_q[ADDR_W-1:2], 2'b00};
   assign dmem_be        = be_q;
   assign dmem_wdata     = wdata_q;
   assign wb_valid       = wb_valid_q;
   assign wb_rd_addr     = wb_rd_q;
   assign wb_data        = wb_data_q;
   assign wb_en          = wb_en_q;
   assign misalign_fault = fault_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: vector table for single-cycle cases,
// hand sequences for load/store handshakes and reset mid-access.
module tb_mem_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [4:0]  rd_addr_in;
   logic [31:0] rd_in;
   logic        writeback_en_in;
   logic        writeback_from_mem_in;
   logic        store_en_in;
   logic [31:0] store_data_in;
   logic [1:0]  mem_size_in;
   logic        mem_unsigned_in;
   logic        stall;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic [3:0]  dmem_be;
   logic        dmem_ready;
   logic        dmem_rvalid;
   logic [31:0] dmem_rdata;
   logic        wb_valid;
   logic [4:0]  wb_rd_addr;
   logic [31:0] wb_data;
   logic        wb_en;
   logic        misalign_fault;

   int checks = 0;
   int errors = 0;

   mem_stage #(.ADDR_W(32)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .rd_addr_in(rd_addr_in), .rd_in(rd_in),
      .writeback_en_in(writeback_en_in), .writeback_from_mem_in(writeback_from_mem_in),
      .store_en_in(store_en_in), .store_data_in(store_data_in), .mem_size_in(mem_size_in),
      .mem_unsigned_in(mem_unsigned_in), .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
      .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ready(dmem_ready),
      .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata), .wb_valid(wb_valid),
      .wb_rd_addr(wb_rd_addr), .wb_data(wb_data), .wb_en(wb_en), .misalign_fault(misalign_fault)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        vld;
      logic [4:0]  rda;
      logic [31:0] rd;
      logic        wen;
      logic        ld;
      logic        st;
      logic [1:0]  sz;
      logic        e_vld;
      logic        e_en;
      logic        e_flt;
      logic        chk_d;
      logic [31:0] e_data;
      logic [4:0]  e_rda;
   } vec_t;

   vec_t vecs[9];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic idle_inputs();
      in_valid = 1'b0; rd_addr_in = 5'd0; rd_in = 32'd0; writeback_en_in = 1'b0;
      writeback_from_mem_in = 1'b0; store_en_in = 1'b0; store_data_in = 32'd0;
      mem_size_in = 2'b00; mem_unsigned_in = 1'b0;
      dmem_ready = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'd0;
   endtask

   task automatic do_load(input string nm, input logic [31:0] a, input logic [1:0] sz,
                          input logic u, input logic [4:0] rda, input logic [31:0] rdata,
                          input int rv_dly, input logic [31:0] e_addr, input logic [3:0] e_be,
                          input logic [31:0] e_data);
      int stalls = 0;
      @(posedge clk); #1;
      in_valid = 1'b1; rd_in = a; rd_addr_in = rda; writeback_en_in = 1'b1;
      writeback_from_mem_in = 1'b1; store_en_in = 1'b0; mem_size_in = sz;
      mem_unsigned_in = u; dmem_ready = 1'b1; dmem_rvalid = 1'b0;
      @(negedge clk);
      if (stall) stalls++;
      check({nm, " issue req"}, dmem_req, 1'b0);
      @(posedge clk); #1;
      @(negedge clk);
      if (stall) stalls++;
      check({nm, " req"}, dmem_req, 1'b1);
      check({nm, " we"}, dmem_we, 1'b0);
      check({nm, " addr"}, dmem_addr, e_addr);
      check({nm, " be"}, dmem_be, e_be);
      for (int i = 0; i < rv_dly; i++) begin
         @(posedge clk); #1;
         dmem_ready = 1'b0;
         @(negedge clk);
         if (stall) stalls++;
         check({nm, " wait req"}, dmem_req, 1'b0);
         check({nm, " wait wb_valid"}, wb_valid, 1'b0);
      end
      @(posedge clk); #1;
      dmem_ready = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = rdata;
      @(negedge clk);
      if (stall) stalls++;
      @(posedge clk); #1;
      in_valid = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'd0;
      @(negedge clk);
      check({nm, " wb_valid"}, wb_valid, 1'b1);
      check({nm, " wb_data"}, wb_data, e_data);
      check({nm, " wb_rd"}, wb_rd_addr, rda);
      check({nm, " wb_en"}, wb_en, 1'b1);
      check({nm, " stall cycles"}, stalls, 2 + rv_dly);
      @(posedge clk); #1;
      @(negedge clk);
      check({nm, " wb_valid drop"}, wb_valid, 1'b0);
   endtask

   task automatic do_store(input string nm, input logic [31:0] a, input logic [1:0] sz,
                           input logic [31:0] d, input int rdy_dly, input logic also_ld,
                           input logic [31:0] e_addr, input logic [3:0] e_be,
                           input logic [31:0] e_wdata);
      int reqs = 0;
      @(posedge clk); #1;
      in_valid = 1'b1; rd_in = a; rd_addr_in = 5'd3; writeback_en_in = also_ld;
      writeback_from_mem_in = also_ld; store_en_in = 1'b1; store_data_in = d;
      mem_size_in = sz; mem_unsigned_in = 1'b0; dmem_ready = 1'b0;
      @(negedge clk);
      check({nm, " issue stall"}, stall, 1'b1);
      check({nm, " issue req"}, dmem_req, 1'b0);
      for (int i = 0; i <= rdy_dly; i++) begin
         @(posedge clk); #1;
         dmem_ready = (i == rdy_dly);
         @(negedge clk);
         if (dmem_req) reqs++;
         check({nm, " we"}, dmem_we, 1'b1);
         check({nm, " addr"}, dmem_addr, e_addr);
         check({nm, " be"}, dmem_be, e_be);
         check({nm, " wdata"}, dmem_wdata, e_wdata);
         check({nm, " stall"}, stall, (i == rdy_dly) ? 1'b0 : 1'b1);
      end
      @(posedge clk); #1;
      in_valid = 1'b0; store_en_in = 1'b0; writeback_from_mem_in = 1'b0; dmem_ready = 1'b0;
      @(negedge clk);
      check({nm, " req cycles"}, reqs, rdy_dly + 1);
      check({nm, " wb_valid"}, wb_valid, 1'b1);
      check({nm, " wb_en"}, wb_en, 1'b0);
      check({nm, " req after"}, dmem_req, 1'b0);
   endtask

   initial begin
      vecs[0] = '{1'b1, 5'd5,  32'h0000_1234, 1'b1, 1'b0, 1'b0, 2'b10, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_1234, 5'd5};
      vecs[1] = '{1'b1, 5'd0,  32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 5'd0};
      vecs[2] = '{1'b0, 5'd9,  32'h0000_FFFF, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 5'd0};
      vecs[3] = '{1'b1, 5'd4,  32'h0000_0401, 1'b1, 1'b1, 1'b0, 2'b10, 1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 5'd0};
      vecs[4] = '{1'b1, 5'd6,  32'h0000_0203, 1'b1, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 5'd0};
      vecs[5] = '{1'b1, 5'd0,  32'h0000_0402, 1'b0, 1'b0, 1'b1, 2'b11, 1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 5'd0};
      vecs[6] = '{1'b1, 5'd8,  32'h0000_0305, 1'b1, 1'b1, 1'b1, 2'b01, 1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 5'd0};
      vecs[7] = '{1'b1, 5'd31, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, 5'd31};
      vecs[8] = '{1'b0, 5'd2,  32'h0000_0042, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 5'd31};

      idle_inputs();
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      check("reset wb_valid", wb_valid, 1'b0);
      check("reset wb_data", wb_data, 32'd0);
      check("reset wb_rd", wb_rd_addr, 5'd0);
      check("reset wb_en", wb_en, 1'b0);
      check("reset fault", misalign_fault, 1'b0);
      check("reset stall", stall, 1'b0);
      check("reset req", dmem_req, 1'b0);
      check("reset be", dmem_be, 4'd0);

      for (int i = 0; i < 9; i++) begin
         @(posedge clk); #1;
         in_valid = vecs[i].vld; rd_addr_in = vecs[i].rda; rd_in = vecs[i].rd;
         writeback_en_in = vecs[i].wen; writeback_from_mem_in = vecs[i].ld;
         store_en_in = vecs[i].st; mem_size_in = vecs[i].sz;
         @(negedge clk);
         check($sformatf("vec%0d stall", i), stall, 1'b0);
         check($sformatf("vec%0d req", i), dmem_req, 1'b0);
         @(posedge clk); #1;
         idle_inputs();
         @(negedge clk);
         check($sformatf("vec%0d wb_valid", i), wb_valid, vecs[i].e_vld);
         check($sformatf("vec%0d wb_en", i), wb_en, vecs[i].e_en);
         check($sformatf("vec%0d fault", i), misalign_fault, vecs[i].e_flt);
         check($sformatf("vec%0d req after", i), dmem_req, 1'b0);
         if (vecs[i].chk_d) begin
            check($sformatf("vec%0d wb_data", i), wb_data, vecs[i].e_data);
            check($sformatf("vec%0d wb_rd", i), wb_rd_addr, vecs[i].e_rda);
         end
      end

      do_load("lb",  32'h103, 2'b00, 1'b0, 5'd7,  32'h80FF_FF12, 0, 32'h100, 4'b1000, 32'hFFFF_FF80);
      do_load("lhu", 32'h202, 2'b01, 1'b1, 5'd9,  32'hBEEF_0000, 1, 32'h200, 4'b1100, 32'h0000_BEEF);
      do_load("lw",  32'h600, 2'b10, 1'b0, 5'd10, 32'h89AB_CDEF, 0, 32'h600, 4'b1111, 32'h89AB_CDEF);
      do_load("lbu", 32'h501, 2'b00, 1'b1, 5'd11, 32'h0000_AB00, 0, 32'h500, 4'b0010, 32'h0000_00AB);
      do_load("lh",  32'h700, 2'b01, 1'b0, 5'd12, 32'h1234_8001, 2, 32'h700, 4'b0011, 32'hFFFF_8001);

      do_store("sh",    32'h302, 2'b01, 32'hAAAA_5678, 3, 1'b0, 32'h300, 4'b1100, 32'h5678_5678);
      do_store("sb",    32'h501, 2'b00, 32'h1234_56AB, 0, 1'b0, 32'h500, 4'b0010, 32'hABAB_ABAB);
      do_store("sw_ld", 32'h800, 2'b10, 32'hCAFE_F00D, 1, 1'b1, 32'h800, 4'b1111, 32'hCAFE_F00D);

      // reset while a load sits in WAIT; the late rvalid must be dropped
      @(posedge clk); #1;
      in_valid = 1'b1; rd_in = 32'h900; rd_addr_in = 5'd13; writeback_en_in = 1'b1;
      writeback_from_mem_in = 1'b1; mem_size_in = 2'b10; dmem_ready = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      dmem_ready = 1'b0; rst = 1'b0; in_valid = 1'b0;
      writeback_from_mem_in = 1'b0; writeback_en_in = 1'b0;
      @(negedge clk);
      check("rstmid wait stall", stall, 1'b1);
      @(posedge clk); #1;
      rst = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'h5555_AAAA;
      @(negedge clk);
      check("rstmid stall", stall, 1'b0);
      check("rstmid req", dmem_req, 1'b0);
      check("rstmid wb_valid", wb_valid, 1'b0);
      check("rstmid wb_data", wb_data, 32'd0);
      check("rstmid wb_rd", wb_rd_addr, 5'd0);
      check("rstmid wb_en", wb_en, 1'b0);
      check("rstmid addr", dmem_addr, 32'd0);
      check("rstmid be", dmem_be, 4'd0);
      check("rstmid wdata", dmem_wdata, 32'd0);
      check("rstmid we", dmem_we, 1'b0);
      @(posedge clk); #1;
      dmem_rvalid = 1'b0;
      @(negedge clk);
      check("rstmid stale wb_valid", wb_valid, 1'b0);
      check("rstmid stale wb_data", wb_data, 32'd0);
      check("rstmid stale req", dmem_req, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the pipelined RV32 core. It sits directly downstream of the EX/M pipeline register and consumes that register's outputs each cycle.
- Non-memory instructions pass straight through to the M/WB outputs.
- Loads and stores run a req/ready/rvalid handshake with data memory, including byte/half/word lane handling and sign/zero extension.
- Drives `stall` back to the EX/M register's skip input until the access completes.

Parameters:
- ADDR_W, 32, width of dmem_addr; the upper bits of rd_in beyond ADDR_W are dropped.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- in_valid  in  1  EX/M holds a live instruction
- rd_addr_in  in  5  destination register
- rd_in  in  32  ALU result; effective address for loads/stores
- writeback_en_in  in  1  instruction writes rd
- writeback_from_mem_in  in  1  instruction is a load
- store_en_in  in  1  instruction is a store
- store_data_in  in  32  rs2 value for stores
- mem_size_in  in  2  00 byte, 01 half, 10 word (11 treated as word)
- mem_unsigned_in  in  1  zero-extend load (LBU/LHU)
- stall  out  1  hold EX/M (drives its skip)
- dmem_req  out  1  memory request valid
- dmem_we  out  1  1 store, 0 load
- dmem_addr  out  ADDR_W  word-aligned address (low 2 bits 0)
- dmem_wdata  out  32  lane-replicated store data
- dmem_be  out  4  byte enables
- dmem_ready  in  1  memory accepts request this cycle
- dmem_rvalid  in  1  load data valid
- dmem_rdata  in  32  load data word
- wb_valid  out  1  M/WB holds a completed instruction
- wb_rd_addr  out  5  destination register to M/WB
- wb_data  out  32  writeback value
- wb_en  out  1  register-file write enable
- misalign_fault  out  1  one-cycle pulse with wb_valid on misaligned access

Behaviour:
- Reset (rst=0 at posedge):
  - state=IDLE; wb_valid=0, wb_rd_addr=0, wb_data=0, wb_en=0, misalign_fault=0.
  - Captured request registers are cleared to 0.
  - Reset mid-operation abandons the access; dmem_req is 0 from the next cycle; a late rvalid in IDLE is ignored.
- mem_op = in_valid & (writeback_from_mem_in | store_en_in). If both flags are set, store takes priority.
- Misaligned = half with addr[0]=1, or word with addr[1:0]!=0.
- States IDLE, REQ, WAIT. dmem_req=1 only in REQ; dmem_we, addr, be and wdata come from captured registers.
- IDLE, in_valid & !mem_op:
  - stall=0.
  - Next edge: wb_valid=1, wb_data=rd_in, wb_rd_addr=rd_addr_in, wb_en=writeback_en_in.
- IDLE, in_valid=0:
  - stall=0.
  - Next edge: wb_valid=0, wb_en=0.
- IDLE, mem_op & misaligned:
  - No memory request; stall=0.
  - Next edge: wb_valid=1, wb_en=0, misalign_fault=1.
- IDLE, mem_op & aligned:
  - stall=1.
  - Capture address, size, unsigned flag, rd_addr, writeback_en and store data.
  - Next state REQ; wb_valid=0.
- REQ:
  - dmem_req held until dmem_ready; request fields are stable while waiting.
  - Store with ready=1: stall=0 that cycle. Next edge: wb_valid=1, wb_en=0, state IDLE.
  - Load with ready=1: stall=1, next state WAIT.
- WAIT:
  - stall=!dmem_rvalid.
  - On rvalid: shift dmem_rdata right by 8*addr[1:0], then sign- or zero-extend from bit 7 (byte) or bit 15 (half).
  - Next edge: wb_valid=1, wb_data=result, wb_en=captured writeback_en; state IDLE.
- Memory contract: rvalid arrives no earlier than the cycle after the ready handshake.
- Latency:
  - ALU op: 1 cycle.
  - Store: at least 2 cycles.
  - Load: at least 3 cycles.
- Byte enables: byte = 0001<<addr[1:0]; half = 0011<<addr[1:0]; word = 1111.
- Store data lanes: byte = {4{d[7:0]}}; half = {2{d[15:0]}}; word = d.
- Output hold: wb_* outputs update only on the edges listed above; they are single-cycle results, and wb_valid=0 in all other cycles.
- rd_addr_in=0 is passed through unchanged; the register file ignores x0.

Test Plan:
- Reset then ALU op: rd_in=0x1234, rd_addr 5, wb_en_in 1 -> next cycle wb_valid=1, wb_data=0x1234, wb_rd_addr=5, stall never high.
- LB, addr 0x103, rdata 0x80FF_FF12, ready and rvalid immediate:
  - dmem_addr=0x100, be=1000.
  - wb_data=0xFFFF_FF80 three cycles after issue.
  - stall high exactly 2 cycles.
- LHU, addr 0x202, rdata 0xBEEF_0000 -> wb_data=0x0000_BEEF, wb_en=1.
- SH, addr 0x302, data 0xAAAA_5678, ready held low 3 cycles:
  - dmem_req high 4 cycles with constant fields; be=1100, wdata=0x5678_5678.
  - Then wb_valid=1, wb_en=0.
- LW at addr 0x401: no dmem_req; next cycle misalign_fault=1, wb_en=0, stall=0 throughout.
- Load in WAIT, rst=0 pulse, then rvalid: state IDLE, all outputs 0, no wb_valid from the stale rvalid.
